// File: rtl/cceip_outbound_if.sv
// Stream bundle between the CCEIP engine output, the outbound block and the mm writer.
// The slave modport is the outbound block's view; master is the surrounding environment.
interface cceip_outbound_if;
    logic        cceip_s_axis_tvalid;
    logic        cceip_s_axis_tready;
    logic        cceip_s_axis_tlast;
    logic [7:0]  cceip_s_axis_tstrb;
    logic [7:0]  cceip_s_axis_tuser;
    logic        cceip_s_axis_tid;
    logic [63:0] cceip_s_axis_tdata;
    logic        mm_m_axis_tvalid;
    logic        mm_m_axis_tready;
    logic        mm_m_axis_tlast;
    logic [7:0]  mm_m_axis_tkeep;
    logic [63:0] mm_m_axis_tdata;

    modport slave (
        input  cceip_s_axis_tvalid, cceip_s_axis_tlast, cceip_s_axis_tstrb,
        input  cceip_s_axis_tuser, cceip_s_axis_tid, cceip_s_axis_tdata,
        output cceip_s_axis_tready,
        output mm_m_axis_tvalid, mm_m_axis_tlast, mm_m_axis_tkeep, mm_m_axis_tdata,
        input  mm_m_axis_tready
    );

    modport master (
        output cceip_s_axis_tvalid, cceip_s_axis_tlast, cceip_s_axis_tstrb,
        output cceip_s_axis_tuser, cceip_s_axis_tid, cceip_s_axis_tdata,
        input  cceip_s_axis_tready,
        input  mm_m_axis_tvalid, mm_m_axis_tlast, mm_m_axis_tkeep, mm_m_axis_tdata,
        output mm_m_axis_tready
    );
endinterface

// File: rtl/cceip_outbound.sv
// Return-path deframer: drops headers and non-data frames, passes data-frame payload to the
// mm writer with zero latency, counts forwarded bytes and captures the job-ending CQE word.
module cceip_outbound #(
    parameter logic [7:0] DATA_FRAME_TYPE = 8'h80,
    parameter int         CNT_W           = 64
) (
    input  logic                 ap_clk,
    input  logic                 areset,
    input  logic                 outbound_start,
    output logic                 outbound_done,
    output logic [CNT_W-1:0]     output_data_size,
    output logic [63:0]          cqe_status,
    output logic [2:0]           err_flags,
    cceip_outbound_if.slave      axis
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR  = 3'd1,
        S_SKIP = 3'd2,
        S_DATA = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_s_tready;
    logic             w_acc;
    logic             w_sot;
    logic             w_eot;
    logic             w_last;
    logic             w_is_data_type;
    logic [CNT_W-1:0] r_size;
    logic [63:0]      r_cqe;
    logic [2:0]       r_err;
    logic             w_unused;

    function automatic logic [3:0] popcnt8(input logic [7:0] v);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < 8; i++) begin
            c = c + {3'b000, v[i]};
        end
        return c;
    endfunction

    assign w_sot          = axis.cceip_s_axis_tuser[0];
    assign w_eot          = axis.cceip_s_axis_tuser[1];
    assign w_last         = axis.cceip_s_axis_tlast;
    assign w_is_data_type = (axis.cceip_s_axis_tdata[63:56] == DATA_FRAME_TYPE);
    assign w_unused       = ^{axis.cceip_s_axis_tid, axis.cceip_s_axis_tuser[7:2]};

    // Ready: headers and skipped frames are always drained; data frames follow the writer.
    always_comb begin
        w_s_tready = 1'b0;
        unique case (r_state)
            S_HDR,
            S_SKIP:  w_s_tready = 1'b1;
            S_DATA:  w_s_tready = axis.mm_m_axis_tready;
            default: w_s_tready = 1'b0;
        endcase
    end

    assign w_acc = axis.cceip_s_axis_tvalid & w_s_tready;

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (outbound_start) w_state_nxt = S_HDR;
            end
            S_HDR: begin
                if (w_acc) begin
                    // The job-ending word wins over any frame marking it carries.
                    if (w_last)
                        w_state_nxt = S_DONE;
                    else if (w_sot && !w_eot)
                        w_state_nxt = w_is_data_type ? S_DATA : S_SKIP;
                end
            end
            S_SKIP,
            S_DATA: begin
                if (w_acc) begin
                    if (w_last)     w_state_nxt = S_DONE;
                    else if (w_eot) w_state_nxt = S_HDR;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (areset) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge ap_clk) begin
        if (areset) begin
            r_size <= '0;
            r_cqe  <= '0;
            r_err  <= '0;
        end else if ((r_state == S_IDLE) && outbound_start) begin
            r_size <= '0;
            r_cqe  <= '0;
            r_err  <= '0;
        end else if (w_acc) begin
            if (w_last) r_cqe <= axis.cceip_s_axis_tdata;
            if ((r_state == S_HDR) && !w_last && !w_sot) r_err[0] <= 1'b1;
            if (r_state == S_DATA) begin
                r_size <= r_size + {{(CNT_W-4){1'b0}}, popcnt8(axis.cceip_s_axis_tstrb)};
                if (w_sot)            r_err[1] <= 1'b1;
                if (w_last && !w_eot) r_err[2] <= 1'b1;
            end
        end
    end

    // Payload path is purely combinational so the writer's stall reaches the engine directly.
    assign axis.cceip_s_axis_tready = w_s_tready;
    assign axis.mm_m_axis_tvalid    = (r_state == S_DATA) & axis.cceip_s_axis_tvalid;
    assign axis.mm_m_axis_tlast     = (r_state == S_DATA) & (w_eot | w_last);
    assign axis.mm_m_axis_tkeep     = axis.cceip_s_axis_tstrb;
    assign axis.mm_m_axis_tdata     = axis.cceip_s_axis_tdata;

    assign outbound_done    = (r_state == S_DONE);
    assign output_data_size = r_size;
    assign cqe_status       = r_cqe;
    assign err_flags        = r_err;

endmodule
